// File: rtl/axis_arb2_pkg.sv
// Shared types and helpers for the two-input AXI-Stream round-robin arbiter.
package axis_arb2_pkg;

    localparam int unsigned DEFAULT_TDATA_WIDTH = 32;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

    // Lone requester wins; on contention the favoured requester wins.
    function automatic src_t rr_grant(input logic v0, input logic v1, input src_t prio);
        if (v0 && v1) begin
            return prio;
        end else if (v1) begin
            return SRC1;
        end else begin
            return SRC0;
        end
    endfunction

endpackage

// File: rtl/axis_slice.sv
// One-entry AXI-Stream register slice with a flush input that drops the held beat.
module axis_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             invalidate,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             s_tready_c,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready
);

    assign s_tready_c = !m_tvalid || m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
        end else if (invalidate) begin
            m_tvalid <= 1'b0;
        end else if (s_tready_c) begin
            m_tvalid <= s_tvalid;
        end
    end

    // Payload is qualified by m_tvalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!invalidate && s_tready_c && s_tvalid) begin
            m_tdata <= s_tdata;
        end
    end

endmodule

// File: rtl/axis_arb2.sv
// Two-input AXI-Stream merge with per-beat round-robin arbitration and a flushable output register.
module axis_arb2
    import axis_arb2_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = DEFAULT_TDATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s0_tvalid,
    input  logic [TDATA_WIDTH-1:0] s0_tdata,
    output logic                   s0_tready,
    input  logic                   s1_tvalid,
    input  logic [TDATA_WIDTH-1:0] s1_tdata,
    output logic                   s1_tready,
    output logic                   m_tvalid,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tid,
    input  logic                   m_tready,
    input  logic                   invalidate
);

    localparam int unsigned PAYLOAD_WIDTH = TDATA_WIDTH + 1;

    src_t                     prio;
    src_t                     grant;
    logic                     any_valid;
    logic                     open;
    logic                     accept;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [PAYLOAD_WIDTH-1:0] held;

    // Grant depends only on tvalid and prio, never on readiness.
    always_comb begin
        grant     = rr_grant(s0_tvalid, s1_tvalid, prio);
        any_valid = s0_tvalid || s1_tvalid;
        payload   = {1'(grant), (grant == SRC1) ? s1_tdata : s0_tdata};
    end

    assign accept    = any_valid && open && !invalidate && !rst;
    assign s0_tready = accept && (grant == SRC0);
    assign s1_tready = accept && (grant == SRC1);

    // Pointer moves to the other requester only when a beat is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= SRC0;
        end else if (accept) begin
            prio <= (grant == SRC0) ? SRC1 : SRC0;
        end
    end

    axis_slice #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .invalidate(invalidate),
        .s_tvalid  (accept),
        .s_tdata   (payload),
        .s_tready_c(open),
        .m_tvalid  (m_tvalid),
        .m_tdata   (held),
        .m_tready  (m_tready)
    );

    assign m_tid   = held[PAYLOAD_WIDTH-1];
    assign m_tdata = held[TDATA_WIDTH-1:0];

endmodule
